fifo_word_unpacker: RTL and testbench
=====================================

# fifo_word_unpacker

Downstream drain stage for the 8-to-32 FIFO. It pops 32-bit words from the FIFO read port and serialises each word into four bytes on a valid/ready byte stream, least-significant byte first. Each word's parity flag is tagged at capture and tallied. A one-word prefetch buffer keeps the output stream free of bubbles while the FIFO stays non-empty.

## Interface
Parameters:
- DATA_WIDTH, 8, output byte width
- READ_WIDTH, 32, FIFO word width; must equal 4*DATA_WIDTH
- ERR_CNT_WIDTH, 8, width of the parity error counter
- DROP_BAD, 1; 1 = discard words tagged with a parity error, 0 = emit them with m_err high

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits new FIFO fetches
- fifo_empty  in  1  FIFO empty flag (fewer than 4 bytes stored)
- fifo_rd_en  out  1  FIFO read strobe, registered, one-cycle pulse
- fifo_r_data  in  READ_WIDTH  FIFO read word, valid in the cycle after the fifo_rd_en cycle
- fifo_parity_error  in  1  FIFO parity flag, qualified together with fifo_r_data
- m_data  out  DATA_WIDTH  output byte
- m_valid  out  1  output byte valid
- m_ready  in  1  sink accepts the byte
- m_last  out  1  byte is lane 3, the last byte of its word
- m_err  out  1  byte belongs to a parity-tagged word (only when DROP_BAD=0)
- err_count  out  ERR_CNT_WIDTH  saturating count of parity-tagged words
- idle  out  1  no fetch in flight, and both the pending and active slots are empty

## Operation
- **Fetch FSM, states F_IDLE, F_REQ, F_CAP:**
  - F_IDLE: move to F_REQ when enable=1, fifo_empty=0, and pend_valid=0.
  - F_REQ: fifo_rd_en=1 for exactly this cycle, then go to F_CAP.
  - F_CAP: latch fifo_r_data into pend_data and fifo_parity_error into pend_bad, then go to F_IDLE.
  - On a tagged capture, err_count increments; it saturates at all-ones.
  - When DROP_BAD=1, a tagged word does not set pend_valid (the word is discarded). Otherwise pend_valid is set to 1.
- **Output slot (act_data, act_bad, act_valid, lane[1:0]):**
  - m_data = act_data[lane*DATA_WIDTH +: DATA_WIDTH].
  - m_valid = act_valid.
  - m_last = act_valid & (lane==3).
  - m_err = act_valid & act_bad.
- **Handshake:** a byte transfers on a clock edge where m_valid=1 and m_ready=1.
  - On a transfer, lane increments.
  - On the lane-3 transfer, lane returns to 0. If pend_valid=1, pend moves to act in the same edge and act_valid stays 1; otherwise act_valid goes to 0.
- **Empty slot load:** when act_valid=0 and pend_valid=1, pend moves to act on the next edge.
  - A move from pend to act clears pend_valid.
- **Outputs stay stable while stalled:** while m_valid=1 and m_ready=0, m_data, m_last and m_err hold their values.
- **enable=0:** blocks only the F_IDLE to F_REQ transition. A fetch already in flight completes, and buffered words keep draining.
- **Fetch gating:** fifo_empty is ignored outside F_IDLE. Because fetches only start when pend_valid=0, there is never more than one read outstanding.

## Timing
- **Reset values (rst_n=0, asynchronous):**
  - Fetch FSM=F_IDLE, fifo_rd_en=0.
  - pend_valid=0, act_valid=0, lane=0, act_data=0.
  - m_valid=0, m_last=0, m_err=0, m_data=0.
  - err_count=0, idle=1.
- **Reset mid-operation:** any word in flight or buffered is lost. The block restarts cleanly from F_IDLE.
- **First-byte latency:**
  - fifo_rd_en high in cycle N.
  - Capture at the end of N+1.
  - Move from pend to act at the end of N+2.
  - m_valid high in N+3.
- **Throughput:** with m_ready held at 1 and the FIFO non-empty, words stream back to back with no bubble after the first word. The next word is prefetched into pend while the current word drains.
- **Read pacing:** minimum spacing between fifo_rd_en pulses is 3 cycles.

## Test plan
- **Single word:** FIFO holds 0xDDCCBBAA, m_ready=1.
  - Exactly one fifo_rd_en pulse.
  - Bytes AA, BB, CC, DD on consecutive cycles starting 3 cycles after fifo_rd_en.
  - m_last only on DD; idle returns to 1.
- **Back-to-back words:** words 0x03020100 and 0x07060504, m_ready=1.
  - Bytes 00 through 07 appear on 8 consecutive m_valid cycles with no gap.
  - Exactly 2 fifo_rd_en pulses.
- **Backpressure:** m_ready=0 for 5 cycles while BB is presented.
  - m_data holds BB and m_valid stays 1.
  - No byte is lost or duplicated after release.
  - No fetch occurs while pend_valid=1.
- **Parity:** three words, the middle one tagged.
  - DROP_BAD=1: 8 bytes from words 1 and 3 only; err_count=1.
  - DROP_BAD=0: 12 bytes, with m_err high on bytes 5-8 only.
  - With ERR_CNT_WIDTH=2 and 5 tagged words, err_count saturates at 3.
- **enable gating:** enable=0 with the FIFO non-empty.
  - fifo_rd_en stays 0 and idle=1.
  - After enable=1, the first fetch occurs on the next cycle.
- **Reset mid-word:** rst_n pulled low after byte BB.
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, the next FIFO word is emitted from lane 0.

Source files
------------

// File: rtl/fifo_word_unpacker_if.sv
// Bundle between fifo_word_unpacker, its upstream FIFO read port and the byte sink.
// Latency: none; this file only declares wires.
// Backpressure: m_ready from the sink stalls the byte stream; the FIFO side has no backpressure.
// Ports: fifo_empty/fifo_rd_en/fifo_r_data/fifo_parity_error form the FIFO read port.
//        m_data/m_valid/m_ready/m_last/m_err form the byte stream.
// master = unpacker view, slave = FIFO + sink view.
interface fifo_word_unpacker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int READ_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [READ_WIDTH-1:0] fifo_r_data;
  logic                  fifo_parity_error;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  m_err;

  modport master (
    input  fifo_empty, fifo_r_data, fifo_parity_error, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, m_err
  );

  modport slave (
    output fifo_empty, fifo_r_data, fifo_parity_error, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, m_err
  );
endinterface

// File: rtl/fifo_word_unpacker.sv
// Drains 32-bit FIFO words and serialises them LSB byte first onto a valid/ready stream.
// Latency: fifo_rd_en in cycle N -> first byte valid in N+3; words stream back to back after that.
// Backpressure: m_ready=0 freezes the current byte; fetches stop once the prefetch slot is full.
// Ports: clk, rst_n (async, active low), enable (permits new fetches),
//        bus (FIFO read port + byte stream, master modport),
//        err_count (saturating count of parity-tagged words), idle (nothing fetched or held).
module fifo_word_unpacker #(
  parameter int DATA_WIDTH    = 8,
  parameter int READ_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int DROP_BAD      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  fifo_word_unpacker_if.master     bus,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     idle
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_CAP  = 2'd2
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic                     rd_en_q, rd_en_d;
  logic [READ_WIDTH-1:0]    pend_data_q, pend_data_d;
  logic                     pend_bad_q, pend_bad_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [READ_WIDTH-1:0]    act_data_q, act_data_d;
  logic                     act_bad_q, act_bad_d;
  logic                     act_valid_q, act_valid_d;
  logic [1:0]               lane_q, lane_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic xfer;
  logic wrap;
  logic load;

  always_comb begin
    state_d      = state_q;
    pend_data_d  = pend_data_q;
    pend_bad_d   = pend_bad_q;
    pend_valid_d = pend_valid_q;
    act_data_d   = act_data_q;
    act_bad_d    = act_bad_q;
    act_valid_d  = act_valid_q;
    lane_d       = lane_q;
    err_cnt_d    = err_cnt_q;

    xfer = act_valid_q & bus.m_ready;
    wrap = xfer & (lane_q == 2'd3);
    // The prefetched word slides into the active slot either when the slot is
    // empty or in the same edge that retires lane 3, so no bubble appears.
    load = pend_valid_q & (~act_valid_q | wrap);

    // Fetches only start with the prefetch slot empty, so at most one read is
    // ever outstanding and a capture can never collide with a full slot.
    unique case (state_q)
      F_IDLE:  if (enable && !bus.fifo_empty && !pend_valid_q) state_d = F_REQ;
      F_REQ:   state_d = F_CAP;
      F_CAP:   state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase

    if (xfer) lane_d = lane_q + 2'd1;  // lane 3 wraps to 0
    if (wrap) act_valid_d = 1'b0;

    if (load) begin
      act_data_d   = pend_data_q;
      act_bad_d    = pend_bad_q;
      act_valid_d  = 1'b1;
      pend_valid_d = 1'b0;
    end

    if (state_q == F_CAP) begin
      pend_data_d  = bus.fifo_r_data;
      pend_bad_d   = bus.fifo_parity_error;
      pend_valid_d = !((DROP_BAD != 0) && bus.fifo_parity_error);
      if (bus.fifo_parity_error && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end
  end

  // Read strobe comes straight from a flop so the FIFO sees a clean pulse.
  assign rd_en_d = (state_d == F_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= F_IDLE;
      rd_en_q      <= 1'b0;
      pend_data_q  <= '0;
      pend_bad_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      act_bad_q    <= 1'b0;
      act_valid_q  <= 1'b0;
      lane_q       <= 2'd0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      pend_data_q  <= pend_data_d;
      pend_bad_q   <= pend_bad_d;
      pend_valid_q <= pend_valid_d;
      act_data_q   <= act_data_d;
      act_bad_q    <= act_bad_d;
      act_valid_q  <= act_valid_d;
      lane_q       <= lane_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.m_data     = act_data_q[lane_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.m_valid    = act_valid_q;
  assign bus.m_last     = act_valid_q & (lane_q == 2'd3);
  assign bus.m_err      = act_valid_q & act_bad_q;
  assign err_count      = err_cnt_q;
  assign idle           = (state_q == F_IDLE) & ~pend_valid_q & ~act_valid_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: instance A drops tagged words (8-bit counter),
// instance B forwards them with m_err (2-bit counter). Each has its own FIFO model and sink.
module tb_fifo_word_unpacker;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_word_unpacker_if #(.DATA_WIDTH(8), .READ_WIDTH(32)) ba ();
  fifo_word_unpacker_if #(.DATA_WIDTH(8), .READ_WIDTH(32)) bb ();

  logic [7:0] ec_a;
  logic [1:0] ec_b;
  logic       idle_a, idle_b;

  fifo_word_unpacker #(.DATA_WIDTH(8), .READ_WIDTH(32), .ERR_CNT_WIDTH(8), .DROP_BAD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(ba), .err_count(ec_a), .idle(idle_a));

  fifo_word_unpacker #(.DATA_WIDTH(8), .READ_WIDTH(32), .ERR_CNT_WIDTH(2), .DROP_BAD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bb), .err_count(ec_b), .idle(idle_b));

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // FIFO contents {parity, word}; received stream entries {err, last, byte}.
  logic [32:0] fq_a[$], fq_b[$];
  logic [9:0]  rx_a[$], rx_b[$];
  int          rxc_a[$], rxc_b[$];
  logic [9:0]  exp_a[$], exp_b[$];
  logic        pop_a = 1'b0, pop_b = 1'b0;
  int          rdcnt_a = 0, rdcnt_b = 0;
  int          last_rd_a = -100, last_rd_b = -100;
  int          kept_a = 0, kept_b = 0, lasts_a = 0, lasts_b = 0;
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [9:0]  prev_a, prev_b;
  logic        ready_a, ready_b, rrand;
  logic [32:0] wa, wb;

  // FIFO A model + sink A. Data is presented only in the cycle after the read
  // strobe; every other cycle carries junk so a mistimed capture is visible.
  always @(negedge clk) begin
    if (!rst_n) begin
      pop_a = 1'b0; kept_a = 0; lasts_a = 0; stall_a = 1'b0;
    end
    if (pop_a) begin
      chk("fifo_a_pop_nonempty", 64'(fq_a.size() > 0), 1);
      wa = (fq_a.size() > 0) ? fq_a.pop_front() : 33'h0;
      if (!wa[32]) kept_a++;
    end else begin
      wa = {1'($urandom_range(0, 1)), 32'($urandom)};
    end
    {ba.fifo_parity_error, ba.fifo_r_data} = wa;
    ba.fifo_empty = (fq_a.size() == 0);
    if (ba.fifo_rd_en) begin
      chk("rd_spacing_a", 64'((cyc - last_rd_a) >= 3), 1);
      // a new fetch may only start while at most the active word is held
      chk("rd_outstanding_a", 64'((kept_a - lasts_a) <= 1), 1);
      rdcnt_a++;
      last_rd_a = cyc;
    end
    pop_a = ba.fifo_rd_en & rst_n;
    ba.m_ready = rrand ? 1'($urandom_range(0, 1)) : ready_a;
    #1;
    if (stall_a && rst_n)
      chk("stall_hold_a", {ba.m_valid, ba.m_err, ba.m_last, ba.m_data}, {1'b1, prev_a});
    if (ba.m_valid && ba.m_ready) begin
      rx_a.push_back({ba.m_err, ba.m_last, ba.m_data});
      rxc_a.push_back(cyc);
      if (ba.m_last) lasts_a++;
    end
    stall_a = ba.m_valid & ~ba.m_ready & rst_n;
    prev_a  = {ba.m_err, ba.m_last, ba.m_data};
  end

  // FIFO B model + sink B (tagged words are kept by this instance).
  always @(negedge clk) begin
    if (!rst_n) begin
      pop_b = 1'b0; kept_b = 0; lasts_b = 0; stall_b = 1'b0;
    end
    if (pop_b) begin
      chk("fifo_b_pop_nonempty", 64'(fq_b.size() > 0), 1);
      wb = (fq_b.size() > 0) ? fq_b.pop_front() : 33'h0;
      kept_b++;
    end else begin
      wb = {1'($urandom_range(0, 1)), 32'($urandom)};
    end
    {bb.fifo_parity_error, bb.fifo_r_data} = wb;
    bb.fifo_empty = (fq_b.size() == 0);
    if (bb.fifo_rd_en) begin
      chk("rd_spacing_b", 64'((cyc - last_rd_b) >= 3), 1);
      chk("rd_outstanding_b", 64'((kept_b - lasts_b) <= 1), 1);
      rdcnt_b++;
      last_rd_b = cyc;
    end
    pop_b = bb.fifo_rd_en & rst_n;
    bb.m_ready = rrand ? 1'($urandom_range(0, 1)) : ready_b;
    #1;
    if (stall_b && rst_n)
      chk("stall_hold_b", {bb.m_valid, bb.m_err, bb.m_last, bb.m_data}, {1'b1, prev_b});
    if (bb.m_valid && bb.m_ready) begin
      rx_b.push_back({bb.m_err, bb.m_last, bb.m_data});
      rxc_b.push_back(cyc);
      if (bb.m_last) lasts_b++;
    end
    stall_b = bb.m_valid & ~bb.m_ready & rst_n;
    prev_b  = {bb.m_err, bb.m_last, bb.m_data};
  end

  // Main process acts 2 time units after each falling edge (monitors sample at +1).
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_rx(input bit which, input int n, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if ((which ? rx_b.size() : rx_a.size()) >= n) break;
      step(1);
    end
    chk(nm, 64'((which ? rx_b.size() : rx_a.size()) >= n), 1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        par;
    logic [31:0] seq;   // expected bytes in emission order, first byte in [31:24]
    logic        err;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] bp_exp[12] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22,
                             8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] par_exp[12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hEE, 8'hEE,
                              8'hEE, 8'hEE, 8'h14, 8'h15, 8'h16, 8'h17};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          r0, r1, en_cyc, ta, tb;
    logic [31:0] rw;
    logic        rp;

    tbl[0] = '{32'hDDCCBBAA, 1'b0, 32'hAABBCCDD, 1'b0};
    tbl[1] = '{32'h03020100, 1'b0, 32'h00010203, 1'b0};
    tbl[2] = '{32'h12345678, 1'b1, 32'h78563412, 1'b1};
    tbl[3] = '{32'hFFFF0000, 1'b0, 32'h0000FFFF, 1'b0};

    rst_n = 1'b1; enable = 1'b0; ready_a = 1'b1; ready_b = 1'b1; rrand = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", ba.fifo_rd_en, 0);
    chk("rst_m_valid", ba.m_valid, 0);
    chk("rst_m_last", ba.m_last, 0);
    chk("rst_m_err", ba.m_err, 0);
    chk("rst_m_data", ba.m_data, 0);
    chk("rst_err_count", ec_a, 0);
    chk("rst_idle", idle_a, 1);
    chk("rst_b_valid", bb.m_valid, 0);
    step(3);
    rst_n = 1'b1; enable = 1'b1;
    step(2);

    // Table: single words through instance B, one at a time.
    for (int v = 0; v < 4; v++) begin
      rx_b.delete(); rxc_b.delete();
      r0 = rdcnt_b;
      fq_b.push_back({tbl[v].par, tbl[v].word});
      wait_rx(1'b1, 4, 40, "tbl_bytes_arrive");
      step(4);
      chk("tbl_byte_count", rx_b.size(), 4);
      for (int i = 0; i < 4 && i < rx_b.size(); i++) begin
        chk("tbl_byte", rx_b[i][7:0], 8'(tbl[v].seq >> (24 - 8 * i)));
        chk("tbl_last", rx_b[i][8], (i == 3));
        chk("tbl_err", rx_b[i][9], tbl[v].err);
      end
      chk("tbl_rd_pulses", rdcnt_b - r0, 1);
      if (rxc_b.size() > 0) chk("tbl_latency", rxc_b[0] - last_rd_b, 3);
      chk("tbl_idle", idle_b, 1);
    end

    // Back-to-back words on A: 8 bytes on consecutive cycles.
    rx_a.delete(); rxc_a.delete();
    r0 = rdcnt_a;
    fq_a.push_back({1'b0, 32'h03020100});
    fq_a.push_back({1'b0, 32'h07060504});
    wait_rx(1'b0, 8, 60, "b2b_bytes_arrive");
    step(4);
    chk("b2b_count", rx_a.size(), 8);
    for (int i = 0; i < 8 && i < rx_a.size(); i++) begin
      chk("b2b_byte", rx_a[i], {1'b0, 1'(i % 4 == 3), 8'(i)});
    end
    if (rxc_a.size() == 8) chk("b2b_no_gap", rxc_a[7] - rxc_a[0], 7);
    chk("b2b_rd_pulses", rdcnt_a - r0, 2);

    // Backpressure on A: hold BB for 5 cycles with a third word waiting in the FIFO.
    rx_a.delete(); rxc_a.delete();
    r0 = rdcnt_a;
    fq_a.push_back({1'b0, 32'hDDCCBBAA});
    fq_a.push_back({1'b0, 32'h44332211});
    fq_a.push_back({1'b0, 32'h88776655});
    wait_rx(1'b0, 1, 40, "bp_first_byte");
    ready_a = 1'b0;
    step(5);
    chk("bp_hold_data", ba.m_data, 8'hBB);
    chk("bp_hold_valid", ba.m_valid, 1);
    chk("bp_no_fetch_while_full", rdcnt_a - r0, 2);
    ready_a = 1'b1;
    wait_rx(1'b0, 12, 80, "bp_bytes_arrive");
    step(4);
    chk("bp_count", rx_a.size(), 12);
    for (int i = 0; i < 12 && i < rx_a.size(); i++) chk("bp_byte", rx_a[i][7:0], bp_exp[i]);
    chk("bp_rd_pulses", rdcnt_a - r0, 3);

    // Parity: middle of three words tagged, on both instances.
    rx_a.delete(); rx_b.delete();
    r0 = rdcnt_a;
    fq_a.push_back({1'b0, 32'h13121110}); fq_b.push_back({1'b0, 32'h13121110});
    fq_a.push_back({1'b1, 32'hEEEEEEEE}); fq_b.push_back({1'b1, 32'hEEEEEEEE});
    fq_a.push_back({1'b0, 32'h17161514}); fq_b.push_back({1'b0, 32'h17161514});
    wait_rx(1'b1, 12, 100, "par_b_arrive");
    wait_rx(1'b0, 8, 100, "par_a_arrive");
    step(6);
    chk("par_a_count", rx_a.size(), 8);
    for (int i = 0; i < 8 && i < rx_a.size(); i++)
      chk("par_a_byte", rx_a[i], {1'b0, 1'(i % 4 == 3), 8'(8'h10 + i)});
    chk("par_a_err_count", ec_a, 1);
    chk("par_a_rd_pulses", rdcnt_a - r0, 3);
    chk("par_b_count", rx_b.size(), 12);
    for (int i = 0; i < 12 && i < rx_b.size(); i++)
      chk("par_b_byte", rx_b[i], {1'(i >= 4 && i < 8), 1'(i % 4 == 3), par_exp[i]});
    chk("par_b_err_count", ec_b, 2);

    // Saturation on B's 2-bit counter.
    rx_b.delete();
    for (int i = 0; i < 5; i++) fq_b.push_back({1'b1, 32'(32'hA0A0A0A0 + i)});
    wait_rx(1'b1, 20, 200, "sat_arrive");
    step(3);
    chk("sat_err_count", ec_b, 3);
    chk("sat_err_flag", rx_b.size() > 0 ? rx_b[rx_b.size() - 1][9] : 1'b0, 1);

    // enable gating on A.
    enable = 1'b0;
    rx_a.delete();
    r0 = rdcnt_a;
    fq_a.push_back({1'b0, 32'h24232221});
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("en_off_idle", idle_a, 1);
    end
    chk("en_off_no_fetch", rdcnt_a - r0, 0);
    enable = 1'b1;
    en_cyc = cyc;
    wait_rx(1'b0, 4, 40, "en_bytes_arrive");
    chk("en_first_fetch_next_cycle", last_rd_a - en_cyc, 1);
    for (int i = 0; i < 4 && i < rx_a.size(); i++) chk("en_byte", rx_a[i][7:0], 8'(8'h21 + i));

    // Reset mid-word on A: after BB transfers, CC is showing.
    step(3);
    rx_a.delete();
    fq_a.push_back({1'b0, 32'hDDCCBBAA});
    wait_rx(1'b0, 2, 40, "rstmid_two_bytes");
    step(1);
    chk("rstmid_pre_valid", ba.m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", ba.m_valid, 0);
    chk("rstmid_data", ba.m_data, 0);
    chk("rstmid_last", ba.m_last, 0);
    chk("rstmid_err", ba.m_err, 0);
    chk("rstmid_rd_en", ba.fifo_rd_en, 0);
    chk("rstmid_err_count", ec_a, 0);
    chk("rstmid_idle", idle_a, 1);
    step(2);
    rst_n = 1'b1;
    rx_a.delete();
    fq_a.push_back({1'b0, 32'h44332211});
    wait_rx(1'b0, 4, 40, "rstmid_next_word");
    step(3);
    chk("rstmid_next_count", rx_a.size(), 4);
    for (int i = 0; i < 4 && i < rx_a.size(); i++)
      chk("rstmid_next_byte", rx_a[i], {1'b0, 1'(i == 3), 8'(8'h11 * (i + 1))});

    // Random traffic, random sink readiness, random enable.
    rx_a.delete(); rx_b.delete(); exp_a.delete(); exp_b.delete();
    ta = 0; tb = 0;
    rrand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        rw = $urandom; rp = ($urandom_range(0, 3) == 0);
        fq_a.push_back({rp, rw});
        if (rp) ta++;
        else for (int i = 0; i < 4; i++) exp_a.push_back({1'b0, 1'(i == 3), 8'(rw >> (8 * i))});
      end
      if ($urandom_range(0, 2) == 0) begin
        rw = $urandom; rp = ($urandom_range(0, 3) == 0);
        fq_b.push_back({rp, rw});
        if (rp) tb++;
        for (int i = 0; i < 4; i++) exp_b.push_back({rp, 1'(i == 3), 8'(rw >> (8 * i))});
      end
      enable = ($urandom_range(0, 7) != 0);
      step(1);
    end
    enable = 1'b1;
    wait_rx(1'b0, exp_a.size(), 3000, "rand_a_drain");
    wait_rx(1'b1, exp_b.size(), 3000, "rand_b_drain");
    step(10);
    rrand = 1'b0;
    chk("rand_a_count", rx_a.size(), exp_a.size());
    chk("rand_b_count", rx_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size() && i < rx_a.size(); i++) chk("rand_a_byte", rx_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < rx_b.size(); i++) chk("rand_b_byte", rx_b[i], exp_b[i]);
    chk("rand_a_err_count", ec_a, (ta > 255) ? 255 : ta);
    chk("rand_b_err_count", ec_b, (tb > 3) ? 3 : tb);
    chk("rand_a_idle", idle_a, 1);
    chk("rand_b_idle", idle_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
